// File: rtl/elgamal_pkg.sv
// Shared types for the ElGamal modexp datapath: divider FSM states and counter sizing.
package elgamal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Iteration counter must hold the value SIZE itself, hence SIZE+1 codes.
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Stream bundle for restoring_divider: dividend/divisor inputs and the joint result output.
interface restoring_divider_if #(
    parameter int SIZE = 128
);
    localparam int HALF = SIZE / 2;

    logic [SIZE-1:0] input_a_tdata;
    logic            input_a_tvalid;
    logic            input_a_tready;
    logic [HALF-1:0] input_b_tdata;
    logic            input_b_tvalid;
    logic            input_b_tready;
    logic [SIZE-1:0] output_q_tdata;
    logic [HALF-1:0] output_r_tdata;
    logic            output_dz;
    logic            output_tvalid;
    logic            output_tready;

    modport master (
        output input_a_tdata, input_a_tvalid, input_b_tdata, input_b_tvalid, output_tready,
        input  input_a_tready, input_b_tready, output_q_tdata, output_r_tdata, output_dz,
        input  output_tvalid
    );

    modport slave (
        input  input_a_tdata, input_a_tvalid, input_b_tdata, input_b_tvalid, output_tready,
        output input_a_tready, input_b_tready, output_q_tdata, output_r_tdata, output_dz,
        output output_tvalid
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
    parameter int HALF = 64
) (
    input  logic [HALF-1:0] rem_in,
    input  logic            q_msb,
    input  logic [HALF-1:0] div,
    output logic [HALF-1:0] rem_out,
    output logic            q_bit
);

    // The extra top bit carries the shifted-out remainder MSB into the compare; after a
    // restore the remainder always fits back into HALF bits.
    logic [HALF:0] shifted;

    assign shifted = {rem_in, q_msb};
    assign q_bit   = (shifted >= {1'b0, div});
    assign rem_out = q_bit ? HALF'(shifted - {1'b0, div}) : shifted[HALF-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV_ZERO_BYPASS_EN to return zero-divisor results immediately instead of iterating.
module restoring_divider
    import elgamal_pkg::*;
#(
    parameter int SIZE = 128
) (
    input  logic               clk,
    input  logic               rst,
    restoring_divider_if.slave bus
);

    localparam int HALF = SIZE / 2;
    localparam int CW   = cnt_width(SIZE);

    div_state_t      state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] q_reg;
    logic [HALF-1:0] div_reg;
    logic [HALF-1:0] rem_reg;
    logic            dz_reg;
    logic            accept;
    logic            b_is_zero;
    logic [HALF-1:0] step_rem;
    logic            step_q;

    assign b_is_zero = (bus.input_b_tdata == '0);

    div_step #(
        .HALF(HALF)
    ) u_div_step (
        .rem_in (rem_reg),
        .q_msb  (q_reg[SIZE-1]),
        .div    (div_reg),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt          = state;
        accept             = 1'b0;
        bus.input_a_tready = 1'b0;
        bus.input_b_tready = 1'b0;
        bus.output_tvalid  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Each channel's ready mirrors the other's valid: both transfer or neither.
                bus.input_a_tready = bus.input_b_tvalid;
                bus.input_b_tready = bus.input_a_tvalid;
                accept             = bus.input_a_tvalid && bus.input_b_tvalid;
                if (accept) begin
`ifdef DIV_ZERO_BYPASS_EN
                    state_nxt = b_is_zero ? ST_DONE : ST_CALC;
`else
                    state_nxt = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (cnt == CW'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.output_tvalid = 1'b1;
                if (bus.output_tready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            q_reg   <= '0;
            div_reg <= '0;
            rem_reg <= '0;
            dz_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        q_reg   <= bus.input_a_tdata;
                        div_reg <= bus.input_b_tdata;
                        rem_reg <= '0;
                        cnt     <= CW'(SIZE);
                        dz_reg  <= b_is_zero;
`ifdef DIV_ZERO_BYPASS_EN
                        // Same values the full iteration would converge to with div == 0.
                        if (b_is_zero) begin
                            q_reg   <= '1;
                            rem_reg <= bus.input_a_tdata[HALF-1:0];
                            cnt     <= '0;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    rem_reg <= step_rem;
                    q_reg   <= {q_reg[SIZE-2:0], step_q};
                    cnt     <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.output_q_tdata = q_reg;
    assign bus.output_r_tdata = rem_reg;
    assign bus.output_dz      = dz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider against an arithmetic reference model.
module tb_restoring_divider;

    localparam int SIZE     = 128;
    localparam int HALF     = SIZE / 2;
    localparam int CALC_LAT = SIZE + 1;
    localparam int TIMEOUT  = 4 * SIZE;
`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = SIZE + 1;
`endif

    typedef struct packed {
        logic [SIZE-1:0] q;
        logic [HALF-1:0] r;
        logic            dz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    restoring_divider_if #(.SIZE(SIZE)) bus ();

    restoring_divider #(
        .SIZE(SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic res_t model(input logic [SIZE-1:0] a, input logic [HALF-1:0] b);
        res_t            m;
        logic [SIZE-1:0] bw;
        bw = {{HALF{1'b0}}, b};
        if (b == '0) begin
            m.q  = '1;
            m.r  = a[HALF-1:0];
            m.dz = 1'b1;
        end else begin
            m.q  = a / bw;
            m.r  = HALF'(a % bw);
            m.dz = 1'b0;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with data/valids already driven; returns at posedge+1 after the transfer edge.
    task automatic handshake(input string tag);
        int n;
        n = 0;
        #1;
        while (!(bus.input_a_tready && bus.input_b_tready) && n < TIMEOUT) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_accept"}, SIZE'(n < TIMEOUT), SIZE'(1));
        @(posedge clk);
        #1;
        bus.input_a_tvalid = 1'b0;
        bus.input_b_tvalid = 1'b0;
    endtask

    task automatic send(input string tag, input logic [SIZE-1:0] a, input logic [HALF-1:0] b);
        bus.input_a_tdata  = a;
        bus.input_b_tdata  = b;
        bus.input_a_tvalid = 1'b1;
        bus.input_b_tvalid = 1'b1;
        handshake(tag);
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.output_tvalid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input res_t exp, input int exp_lat, input int lat);
        check({tag, "_lat"}, SIZE'(lat), SIZE'(exp_lat));
        check({tag, "_q"}, bus.output_q_tdata, exp.q);
        check({tag, "_r"}, SIZE'(bus.output_r_tdata), SIZE'(exp.r));
        check({tag, "_dz"}, SIZE'(bus.output_dz), SIZE'(exp.dz));
    endtask

    task automatic collect(input string tag);
        bus.output_tready = 1'b1;
        @(posedge clk);
        #1;
        bus.output_tready = 1'b0;
        check({tag, "_tvalid_drop"}, SIZE'(bus.output_tvalid), SIZE'(0));
    endtask

    task automatic run_op(input string tag, input logic [SIZE-1:0] a, input logic [HALF-1:0] b,
                          input res_t exp, input int exp_lat);
        int lat;
        send(tag, a, b);
        wait_result(lat);
        check_result(tag, exp, exp_lat, lat);
        collect(tag);
    endtask

    initial begin
        res_t            exp;
        res_t            exp2;
        int              lat;
        logic [SIZE-1:0] ra;
        logic [HALF-1:0] rb;

        bus.input_a_tdata  = '0;
        bus.input_a_tvalid = 1'b0;
        bus.input_b_tdata  = '0;
        bus.input_b_tvalid = 1'b0;
        bus.output_tready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_q", bus.output_q_tdata, '0);
        check("rst_r", SIZE'(bus.output_r_tdata), '0);
        check("rst_dz", SIZE'(bus.output_dz), '0);
        check("rst_tvalid", SIZE'(bus.output_tvalid), '0);
        check("rst_a_tready", SIZE'(bus.input_a_tready), '0);
        check("rst_b_tready", SIZE'(bus.input_b_tready), '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Small directed quotient.
        exp = '{q: SIZE'(14), r: HALF'(2), dz: 1'b0};
        run_op("t1", SIZE'(100), HALF'(7), exp, CALC_LAT);

        // Largest operands: (2^64-1)(2^64+1) = 2^128-1.
        exp = '{q: {{(HALF-1){1'b0}}, 1'b1, {(HALF-1){1'b0}}, 1'b1}, r: '0, dz: 1'b0};
        run_op("t2", '1, '1, exp, CALC_LAT);

        // Zero divisor.
        exp = '{q: '1, r: HALF'(16'h1234), dz: 1'b1};
        run_op("t3", SIZE'(16'h1234), '0, exp, ZERO_LAT);

        // Downstream stall in DONE with the next operation already offered.
        exp  = model(SIZE'(123456789), HALF'(1000));
        exp2 = model({32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h0badf00d}, HALF'(32'h7fff_0001));
        send("t4a", SIZE'(123456789), HALF'(1000));
        wait_result(lat);
        check_result("t4a", exp, CALC_LAT, lat);
        bus.input_a_tdata  = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h0badf00d};
        bus.input_b_tdata  = HALF'(32'h7fff_0001);
        bus.input_a_tvalid = 1'b1;
        bus.input_b_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t4_hold_tvalid", SIZE'(bus.output_tvalid), SIZE'(1));
            check("t4_hold_q", bus.output_q_tdata, exp.q);
            check("t4_hold_r", SIZE'(bus.output_r_tdata), SIZE'(exp.r));
            check("t4_hold_dz", SIZE'(bus.output_dz), SIZE'(exp.dz));
            check("t4_hold_a_tready", SIZE'(bus.input_a_tready), '0);
            check("t4_hold_b_tready", SIZE'(bus.input_b_tready), '0);
        end
        bus.output_tready = 1'b1;
        @(posedge clk);
        #1;
        bus.output_tready = 1'b0;
        check("t4_idle_tvalid", SIZE'(bus.output_tvalid), '0);
        check("t4_idle_a_tready", SIZE'(bus.input_a_tready), SIZE'(1));
        check("t4_idle_b_tready", SIZE'(bus.input_b_tready), SIZE'(1));
        @(posedge clk);
        #1;
        bus.input_a_tvalid = 1'b0;
        bus.input_b_tvalid = 1'b0;
        wait_result(lat);
        check_result("t4b", exp2, CALC_LAT, lat);
        collect("t4b");

        // Dividend offered alone: no transfer until the divisor shows up.
        bus.input_a_tdata  = SIZE'(5000);
        bus.input_b_tdata  = HALF'(0);
        bus.input_a_tvalid = 1'b1;
        bus.input_b_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t5_a_tready", SIZE'(bus.input_a_tready), '0);
            check("t5_tvalid", SIZE'(bus.output_tvalid), '0);
        end
        bus.input_b_tdata  = HALF'(77);
        bus.input_b_tvalid = 1'b1;
        handshake("t5");
        wait_result(lat);
        exp = '{q: SIZE'(64), r: HALF'(72), dz: 1'b0};
        check_result("t5", exp, CALC_LAT, lat);
        collect("t5");

        // Asynchronous reset in the middle of an iteration run.
        send("t6a", {4{32'hcafef00d}}, HALF'(3));
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_q", bus.output_q_tdata, '0);
        check("t6_rst_r", SIZE'(bus.output_r_tdata), '0);
        check("t6_rst_dz", SIZE'(bus.output_dz), '0);
        check("t6_rst_tvalid", SIZE'(bus.output_tvalid), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_post_tvalid", SIZE'(bus.output_tvalid), '0);
        exp = '{q: SIZE'(30), r: HALF'(10), dz: 1'b0};
        run_op("t6b", SIZE'(1000), HALF'(33), exp, CALC_LAT);

        // Random operands with divisors of varying magnitude.
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom};
            rb = rb >> $urandom_range(0, HALF - 1);
            if (i == 3) rb = '0;
            if (i == 5) ra = SIZE'(rb) - SIZE'(1);
            exp = model(ra, rb);
            run_op($sformatf("rnd%0d", i), ra, rb, exp, (rb == '0) ? ZERO_LAT : CALC_LAT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
